instr_stream_loader: RTL and testbench
======================================

INSTR_STREAM_LOADER -- requirements
Module: instr_stream_loader

Interface
REQ-001 Parameter WORD_W, default 8: width of one incoming instruction word slice.
REQ-002 Parameter WORDS_PER_INSTR, default 11: slices packed into one instruction-memory write.
REQ-003 Parameter ADDR_W, default 15: instruction-memory address width.
REQ-004 Parameter MAX_INSTR, default 3000: maximum number of instruction-memory writes per load.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  upstream slice valid.
REQ-008 s_ready  output  1  loader accepts a slice this cycle.
REQ-009 s_data  input  WORD_W  slice payload.
REQ-010 s_last  input  1  marks the final slice of the program; qualified by s_valid&&s_ready.
REQ-011 wr_vld  output  1  instruction write valid; drives the core's i_instr_mem_wr_vld.
REQ-012 wr_rdy  input  1  core instruction memory ready; from o_instr_mem_wr_rdy.
REQ-013 wr_addr  output  ADDR_W  write address, 0-based.
REQ-014 wr_data  output  WORD_W*WORDS_PER_INSTR  packed instruction.
REQ-015 wr_finish  output  1  load complete; drives i_instr_mem_wr_finish.
REQ-016 overflow  output  1  sticky: input arrived after MAX_INSTR writes were issued.
REQ-017 instr_count  output  ADDR_W+1  number of completed write handshakes.

Function
REQ-018 States SHALL be FILL, WRITE and DONE; FILL is entered on reset.
REQ-019 In FILL, s_ready SHALL be 1; each accepted slice k (0..WORDS_PER_INSTR-1) SHALL be stored at wr_data bits [k*WORD_W +: WORD_W], so the first slice occupies the LSBs.
REQ-020 When slice WORDS_PER_INSTR-1 is accepted at edge N, the state SHALL change to WRITE and wr_vld SHALL be 1 from edge N onward (1-cycle latency).
REQ-021 When s_last is accepted on slice k < WORDS_PER_INSTR-1, the remaining slices SHALL be zero-filled, and the state SHALL change to WRITE on the same edge.
REQ-022 In WRITE, s_ready SHALL be 0, and wr_data/wr_addr SHALL hold stable until wr_vld&&wr_rdy.
REQ-023 On handshake, wr_addr and instr_count SHALL increment by 1 and the slice index SHALL clear. The next state SHALL be DONE if the instruction held s_last or instr_count reaches MAX_INSTR; otherwise it SHALL be FILL.
REQ-024 In DONE: wr_finish=1 (held), wr_vld=0, s_ready=0; DONE SHALL be exited only by reset.
REQ-025 If s_valid=1 while in DONE because MAX_INSTR was reached (no s_last seen), overflow SHALL set and stay set.
REQ-026 wr_rdy=0 in WRITE SHALL stall indefinitely with no data loss or repeat.
REQ-027 s_valid=0 in FILL SHALL pause packing; the partial instruction SHALL be retained.
REQ-028 s_last accepted together with slice WORDS_PER_INSTR-1 SHALL produce exactly one write, followed by DONE.
REQ-029 s_last with zero slices SHALL NOT be possible; an empty program is signalled by never asserting s_valid, and wr_finish then stays 0.
REQ-030 wr_addr SHALL NOT wrap; MAX_INSTR SHALL be at most 2**ADDR_W.

Reset
REQ-031 On rst_n=0, the following SHALL clear immediately (asynchronously): wr_vld=0, wr_finish=0, overflow=0, wr_addr=0, wr_data=0, instr_count=0, slice index=0, state FILL; s_ready SHALL be 1 one cycle after deassertion.
REQ-032 Reset asserted mid-WRITE or mid-FILL SHALL discard the partial or pending instruction, with no spurious wr_vld after release.

Verification
REQ-033 22 slices 0x01..0x16 (s_last on 0x16), wr_rdy=1 -> two writes: addr0 data 0x0B0A..01, addr1 data 0x1615..0C; then wr_finish=1 and instr_count=2.
REQ-034 3 slices 0xAA,0xBB,0xCC with s_last on 0xCC -> one write at addr0 with data 0x...00CCBBAA (upper 8 slices zero), then DONE.
REQ-035 wr_rdy held 0 for 20 cycles after wr_vld rises -> wr_data/wr_addr constant, s_ready=0 throughout; a single handshake when wr_rdy rises.
REQ-036 MAX_INSTR=2, 33 slices without s_last -> two writes, wr_finish=1, then overflow=1 when slice 23 is presented; no third write.
REQ-037 rst_n pulsed low during WRITE with wr_rdy=0 -> all outputs zero at once; after release, a new 11-slice stream writes at addr0.
REQ-038 Random s_valid and wr_rdy gaps over a 300-instruction program -> written data matches a reference packing model, and addresses are 0..299 contiguous.

Source files
------------

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs a stream of WORD_W-bit slices into wide
// instruction words and writes them, one per handshake, into the core's
// instruction memory starting at address 0. A load ends on s_last or after
// MAX_INSTR writes; the DONE state then holds wr_finish until reset.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both 1. Upstream keeps s_data/s_last stable while s_valid && !s_ready;
// this block keeps wr_data/wr_addr stable while wr_vld && !wr_rdy.
module instr_stream_loader #(
    parameter int WORD_W          = 8,
    parameter int WORDS_PER_INSTR = 11,
    parameter int ADDR_W          = 15,
    parameter int MAX_INSTR       = 3000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [WORD_W-1:0]                 s_data,
    input  logic                              s_last,
    output logic                              wr_vld,
    input  logic                              wr_rdy,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic [WORD_W*WORDS_PER_INSTR-1:0] wr_data,
    output logic                              wr_finish,
    output logic                              overflow,
    output logic [ADDR_W:0]                   instr_count,
    output logic [1:0]                        state_dbg
);

    localparam int DATA_W = WORD_W * WORDS_PER_INSTR;
    localparam int IDX_W  = $clog2(WORDS_PER_INSTR + 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS_PER_INSTR - 1);
    localparam logic [ADDR_W:0]   MAX_CNT  = (ADDR_W+1)'(MAX_INSTR);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              rdy_en_q;

    logic accept;

    // s_ready is held low during reset and for the first cycle after release.
    assign s_ready     = rdy_en_q && (state_q == ST_FILL);
    assign accept      = s_valid && s_ready;
    assign wr_vld      = (state_q == ST_WRITE);
    assign wr_finish   = (state_q == ST_DONE);
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;
    assign overflow    = ovf_q;
    assign instr_count = cnt_q;
    assign state_dbg   = state_q;

    // Next-state logic: pack slices in FILL, wait for the memory in WRITE,
    // park in DONE and flag any input arriving after a MAX_INSTR cut-off.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    // data_q is all-zero at the start of every instruction,
                    // so a short final instruction is zero-filled for free.
                    data_d[idx_q*WORD_W +: WORD_W] = s_data;
                    if (s_last) begin
                        last_d = 1'b1;
                    end
                    if (s_last || (idx_q == LAST_IDX)) begin
                        state_d = ST_WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_rdy) begin
                    cnt_d  = cnt_q + CNT_ONE;
                    // Saturate rather than wrap when MAX_INSTR == 2**ADDR_W.
                    addr_d = (addr_q == ADDR_TOP) ? addr_q : addr_q + ADDR_ONE;
                    idx_d  = '0;
                    data_d = '0;
                    if (last_q || ((cnt_q + CNT_ONE) == MAX_CNT)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                if (s_valid && !last_q) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State registers, all cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    // Delays s_ready by one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Testbench for instr_stream_loader: directed scenarios plus a long random
// program, checked against a slice-packing reference model.
module tb_instr_stream_loader;

    localparam int WW  = 8;
    localparam int WPI = 11;
    localparam int AW  = 15;
    localparam int DW  = WW * WPI;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT (default MAX_INSTR)
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic [WW-1:0] s_data  = '0;
    logic          wr_rdy  = 1'b0;
    logic          s_ready, wr_vld, wr_finish, overflow;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   instr_count;
    logic [1:0]    state_dbg;

    instr_stream_loader dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_finish(wr_finish), .overflow(overflow), .instr_count(instr_count),
        .state_dbg(state_dbg)
    );

    // second DUT with MAX_INSTR = 2 for the overflow scenario
    logic          m_rst_n   = 1'b0;
    logic          m_s_valid = 1'b0;
    logic [WW-1:0] m_s_data  = '0;
    logic          m_s_ready, m_wr_vld, m_wr_finish, m_overflow;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic [AW:0]   m_instr_count;
    logic [1:0]    m_state_dbg;

    instr_stream_loader #(.MAX_INSTR(2)) dut_max (
        .clk(clk), .rst_n(m_rst_n),
        .s_valid(m_s_valid), .s_ready(m_s_ready), .s_data(m_s_data), .s_last(1'b0),
        .wr_vld(m_wr_vld), .wr_rdy(1'b1), .wr_addr(m_wr_addr), .wr_data(m_wr_data),
        .wr_finish(m_wr_finish), .overflow(m_overflow), .instr_count(m_instr_count),
        .state_dbg(m_state_dbg)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [WW-1:0] prog[$];
    int            exp_addr = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int            m_writes = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: consecutive groups of WPI slices, first slice in the
    // LSBs; a short final group is padded with zero slices
    task automatic build_expect();
        logic [DW-1:0] instr;
        int k;
        instr = '0;
        k = 0;
        for (int i = 0; i < prog.size(); i++) begin
            instr[k*WW +: WW] = prog[i];
            k++;
            if (k == WPI || i == prog.size() - 1) begin
                exp_q.push_back(instr);
                instr = '0;
                k = 0;
            end
        end
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        wr_rdy   = (m == 0);
    endtask

    // wr_rdy driver for random mode
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) wr_rdy = 1'($urandom_range(1));
        end
    end

    // scoreboard: every write handshake must match the next expected word
    always @(negedge clk) begin
        if (rst_n && wr_vld && wr_rdy) begin
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("wr_data", wr_data, exp_q[0]);
                chk("wr_addr", wr_addr, exp_addr);
                void'(exp_q.pop_front());
                exp_addr++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_rst_n && m_wr_vld) m_writes++;
    end

    // driver tasks
    task automatic send_slice(input logic [WW-1:0] d, input logic last, input int gap);
        int t;
        while (int'($urandom_range(99)) < gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        t = 0;
        while (s_ready !== 1'b1 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_timeout", t < 500, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_program(input logic with_last, input int gap);
        for (int i = 0; i < prog.size(); i++) begin
            send_slice(prog[i], with_last && (i == prog.size() - 1), gap);
        end
    endtask

    task automatic wait_finish(input int budget);
        int t;
        t = 0;
        while (wr_finish !== 1'b1 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("finish_timeout", wr_finish, 1);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        exp_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(WW'($urandom_range(255)));
    endtask

    // global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    int t;
    logic [DW-1:0] held;

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_vld", wr_vld, 0);
        chk("rst_wr_finish", wr_finish, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_s_ready", s_ready, 0);
        rst_n   = 1'b1;
        m_rst_n = 1'b1;
        chk("s_ready_at_release", s_ready, 0);
        @(posedge clk);
        #1;
        chk("s_ready_after_release", s_ready, 1);

        // two full instructions, slices 0x01..0x16
        set_mode(0);
        prog.delete();
        for (int i = 1; i <= 22; i++) prog.push_back(WW'(i));
        build_expect();
        send_program(1'b1, 0);
        wait_finish(100);
        chk("two_count", instr_count, 2);
        chk("two_wr_vld", wr_vld, 0);
        chk("two_s_ready", s_ready, 0);
        chk("two_all_written", exp_q.size(), 0);

        // short program with zero fill
        do_reset();
        prog.delete();
        prog.push_back(8'hAA);
        prog.push_back(8'hBB);
        prog.push_back(8'hCC);
        build_expect();
        send_program(1'b1, 0);
        wait_finish(100);
        chk("short_count", instr_count, 1);
        chk("short_all_written", exp_q.size(), 0);

        // stall: wr_rdy low for 20 cycles, s_last on slice WPI-1
        do_reset();
        set_mode(2);
        random_prog(WPI);
        build_expect();
        send_program(1'b1, 0);
        chk("stall_vld_latency", wr_vld, 1);
        held = exp_q[0];
        for (int i = 0; i < 20; i++) begin
            chk("stall_data", wr_data, held);
            chk("stall_addr", wr_addr, 0);
            chk("stall_s_ready", s_ready, 0);
            chk("stall_vld", wr_vld, 1);
            @(posedge clk);
            #1;
        end
        set_mode(0);
        wait_finish(100);
        chk("stall_count", instr_count, 1);
        chk("stall_all_written", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_no_extra_write", exp_addr, 1);

        // reset during WRITE
        do_reset();
        set_mode(2);
        random_prog(WPI);
        build_expect();
        send_program(1'b0, 0);
        chk("pre_reset_vld", wr_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_vld", wr_vld, 0);
        chk("midrst_wr_finish", wr_finish, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_instr_count", instr_count, 0);
        chk("midrst_s_ready", s_ready, 0);
        exp_q.delete();
        exp_addr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_mode(0);
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_no_vld", wr_vld, 0);
        random_prog(WPI);
        build_expect();
        send_program(1'b1, 0);
        wait_finish(100);
        chk("postrst_count", instr_count, 1);
        chk("postrst_next_addr", exp_addr, 1);

        // reset during FILL discards the partial instruction
        do_reset();
        random_prog(5);
        send_program(1'b0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("fillrst_no_vld", wr_vld, 0);
        chk("fillrst_count", instr_count, 0);

        // long random program with gaps on both sides
        do_reset();
        set_mode(1);
        random_prog(299 * WPI + int'($urandom_range(1, WPI)));
        build_expect();
        send_program(1'b1, 30);
        wait_finish(500);
        chk("rand_count", instr_count, 300);
        chk("rand_addr_span", exp_addr, 300);
        chk("rand_all_written", exp_q.size(), 0);
        set_mode(0);

        // MAX_INSTR = 2: 22 slices fill both writes, slice 23 overflows
        for (int i = 0; i < 22; i++) begin
            m_s_valid = 1'b1;
            m_s_data  = WW'(i + 1);
            t = 0;
            while (m_s_ready !== 1'b1 && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("m_accept_timeout", t < 100, 1);
            @(posedge clk);
            #1;
        end
        m_s_valid = 1'b0;
        t = 0;
        while (m_wr_finish !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("m_finish", m_wr_finish, 1);
        chk("m_count", m_instr_count, 2);
        chk("m_writes", m_writes, 2);
        chk("m_no_overflow_yet", m_overflow, 0);
        m_s_valid = 1'b1;
        m_s_data  = WW'(23);
        @(posedge clk);
        #1;
        chk("m_overflow_set", m_overflow, 1);
        chk("m_s_ready_done", m_s_ready, 0);
        for (int i = 24; i <= 33; i++) begin
            m_s_data = WW'(i);
            @(posedge clk);
            #1;
        end
        m_s_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("m_overflow_sticky", m_overflow, 1);
        chk("m_no_third_write", m_writes, 2);
        chk("m_vld_low", m_wr_vld, 0);
        chk("m_addr_final", m_wr_addr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
